// File: rtl/data_mem_responder_if.sv
// Load/store request and completion signals between the core and the data-memory responder.
// The core drives the request side; the responder drives stall/done/err/read_data.
interface data_mem_responder_if;
   logic        data_mem_read_enable;
   logic        data_mem_write_enable;
   logic [31:0] addr;
   logic [31:0] write_data;
   logic [2:0]  funct3;
   logic [31:0] read_data;
   logic        stall;
   logic        done;
   logic        err;

   modport master (
      output data_mem_read_enable, data_mem_write_enable, addr, write_data, funct3,
      input  read_data, stall, done, err
   );

   modport slave (
      input  data_mem_read_enable, data_mem_write_enable, addr, write_data, funct3,
      output read_data, stall, done, err
   );
endinterface

// File: rtl/data_mem_responder.sv
// Fixed-latency data-memory responder: byte/halfword/word loads and stores into a
// lane-split local memory, stalling the core until a one-cycle done/err pulse.
module data_mem_responder #(
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 2
) (
   input  logic clk,
   input  logic rst_n,
   data_mem_responder_if.slave bus
);
   localparam int AW = $clog2(DEPTH_WORDS);
   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t      state_reg;
   logic [3:0]  count_reg;
   logic [31:0] addr_reg;
   logic [31:0] wdata_reg;
   logic [2:0]  funct3_reg;
   logic        is_write_reg;
   logic        conflict_reg;
   logic [31:0] read_data_reg;
   logic        done_reg;
   logic        err_reg;

   logic        req;
   logic        accept;
   logic        commit;
   logic        funct3_bad;
   logic        misaligned;
   logic        out_of_range;
   logic        access_err;
   logic [3:0]  lane_mask;
   logic [31:0] store_bytes;
   logic [3:0]  mem_we;
   logic [31:0] raw_word;
   logic [31:0] shifted;
   logic [31:0] load_value;
   logic [AW-1:0] rd_idx;
   logic [AW-1:0] wr_idx;

   assign req    = bus.data_mem_read_enable | bus.data_mem_write_enable;
   assign accept = (state_reg == IDLE) && req;
   assign commit = (state_reg == BUSY) && (count_reg == 4'd0);

   // Error decode works purely on the latched request so the core may change its inputs mid-access.
   always_comb begin
      funct3_bad   = is_write_reg ? (funct3_reg[2] || (funct3_reg[1:0] == 2'b11))
                                  : ((funct3_reg[1:0] == 2'b11) || (funct3_reg == 3'b110));
      misaligned   = ((funct3_reg[1:0] == 2'b01) && addr_reg[0]) ||
                     ((funct3_reg[1:0] == 2'b10) && (addr_reg[1:0] != 2'b00));
      out_of_range = addr_reg[31:2] >= 30'(DEPTH_WORDS);
      access_err   = conflict_reg || funct3_bad || misaligned || out_of_range;
   end

   always_comb begin
      lane_mask   = 4'b1111;
      store_bytes = wdata_reg;
      case (funct3_reg[1:0])
         2'b00: begin
            lane_mask   = 4'b0001 << addr_reg[1:0];
            store_bytes = {4{wdata_reg[7:0]}};
         end
         2'b01: begin
            lane_mask   = 4'b0011 << {addr_reg[1], 1'b0};
            store_bytes = {2{wdata_reg[15:0]}};
         end
         default: begin
            lane_mask   = 4'b1111;
            store_bytes = wdata_reg;
         end
      endcase
   end

   // Read address follows the incoming request on the accept edge so the word is ready in BUSY.
   assign rd_idx = accept ? bus.addr[AW+1:2] : addr_reg[AW+1:2];
   assign wr_idx = addr_reg[AW+1:2];

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : gen_lane
         logic [7:0] lane_mem [DEPTH_WORDS];
         logic [7:0] lane_q_reg;

         assign mem_we[gi] = commit && is_write_reg && !access_err && lane_mask[gi];

         always_ff @(posedge clk) begin
            if (mem_we[gi]) begin
               lane_mem[wr_idx] <= store_bytes[gi*8 +: 8];
            end
            lane_q_reg <= lane_mem[rd_idx];
         end

         assign raw_word[gi*8 +: 8] = lane_q_reg;
      end
   endgenerate

   always_comb begin
      shifted = raw_word >> {addr_reg[1:0], 3'b000};
      case (funct3_reg)
         3'b000:  load_value = {{24{shifted[7]}}, shifted[7:0]};
         3'b001:  load_value = {{16{shifted[15]}}, shifted[15:0]};
         3'b100:  load_value = {24'd0, shifted[7:0]};
         3'b101:  load_value = {16'd0, shifted[15:0]};
         default: load_value = raw_word;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         count_reg     <= 4'd0;
         addr_reg      <= 32'd0;
         wdata_reg     <= 32'd0;
         funct3_reg    <= 3'd0;
         is_write_reg  <= 1'b0;
         conflict_reg  <= 1'b0;
         read_data_reg <= 32'd0;
         done_reg      <= 1'b0;
         err_reg       <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         err_reg  <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (req) begin
                  addr_reg     <= bus.addr;
                  wdata_reg    <= bus.write_data;
                  funct3_reg   <= bus.funct3;
                  is_write_reg <= bus.data_mem_write_enable;
                  conflict_reg <= bus.data_mem_read_enable & bus.data_mem_write_enable;
                  count_reg    <= CNT_INIT;
                  state_reg    <= BUSY;
               end
            end
            BUSY: begin
               if (count_reg == 4'd0) begin
                  state_reg <= DONE;
                  done_reg  <= 1'b1;
                  err_reg   <= access_err;
                  if (access_err) begin
                     read_data_reg <= 32'd0;
                  end else if (!is_write_reg) begin
                     read_data_reg <= load_value;
                  end
               end else begin
                  count_reg <= count_reg - 4'd1;
               end
            end
            DONE: begin
               // Enables still high here belong to the completing instruction.
               state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign bus.stall     = (state_reg == BUSY) || accept;
   assign bus.done      = done_reg;
   assign bus.err       = err_reg;
   assign bus.read_data = read_data_reg;
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: two instances (latency 2 and 1) driven with directed and
// random load/store traffic, checked every cycle against a byte-array reference model.
module tb_data_mem_responder;
   localparam int DEPTH = 256;
   localparam int LAT0  = 2;
   localparam int LAT1  = 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   data_mem_responder_if bus0();
   data_mem_responder_if bus1();

   data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
   data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

   logic        req_rd    [2];
   logic        req_wr    [2];
   logic [31:0] req_addr  [2];
   logic [31:0] req_wdata [2];
   logic [2:0]  req_f3    [2];

   assign bus0.data_mem_read_enable  = req_rd[0];
   assign bus0.data_mem_write_enable = req_wr[0];
   assign bus0.addr                  = req_addr[0];
   assign bus0.write_data            = req_wdata[0];
   assign bus0.funct3                = req_f3[0];
   assign bus1.data_mem_read_enable  = req_rd[1];
   assign bus1.data_mem_write_enable = req_wr[1];
   assign bus1.addr                  = req_addr[1];
   assign bus1.write_data            = req_wdata[1];
   assign bus1.funct3                = req_f3[1];

   logic        obs_stall [2];
   logic        obs_done  [2];
   logic        obs_err   [2];
   logic [31:0] obs_rdata [2];

   assign obs_stall[0] = bus0.stall;
   assign obs_done[0]  = bus0.done;
   assign obs_err[0]   = bus0.err;
   assign obs_rdata[0] = bus0.read_data;
   assign obs_stall[1] = bus1.stall;
   assign obs_done[1]  = bus1.done;
   assign obs_err[1]   = bus1.err;
   assign obs_rdata[1] = bus1.read_data;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic int lat_of(int i);
      return (i == 0) ? LAT0 : LAT1;
   endfunction

   // Reference model: a flat little-endian byte array per instance plus one pending request.
   logic [7:0]  mm [2][DEPTH*4];
   bit          pend      [2];
   int          pend_done [2];
   bit          p_rd      [2];
   bit          p_wr      [2];
   logic [31:0] p_addr    [2];
   logic [31:0] p_wdata   [2];
   logic [2:0]  p_f3      [2];
   logic [31:0] held      [2] = '{32'd0, 32'd0};
   int          cyc = 0;

   function automatic void model_exec(int i, output bit e, output bit is_load, output logic [31:0] v);
      int size;
      bit legal;
      size    = (p_f3[i][1:0] == 2'd0) ? 1 : (p_f3[i][1:0] == 2'd1) ? 2 : 4;
      legal   = p_wr[i] ? (p_f3[i] inside {3'd0, 3'd1, 3'd2})
                        : (p_f3[i] inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      e       = (p_rd[i] && p_wr[i]) || !legal || ((p_addr[i] % 32'(size)) != 32'd0) ||
                ((p_addr[i] >> 2) >= 32'(DEPTH));
      is_load = p_rd[i] && !p_wr[i];
      v       = 32'd0;
      if (e) return;
      if (p_wr[i]) begin
         for (int k = 0; k < size; k++) mm[i][p_addr[i] + 32'(k)] = p_wdata[i][8*k +: 8];
      end else begin
         for (int k = 0; k < size; k++) v = v | (32'(mm[i][p_addr[i] + 32'(k)]) << (8*k));
         if (!p_f3[i][2] && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8*size));
      end
   endfunction

   // Per-cycle compare of both instances against the model.
   initial begin
      bit          e_m;
      bit          ld_m;
      logic [31:0] v_m;
      forever begin
         @(negedge clk);
         cyc++;
         for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
               pend[i] = 1'b0;
               held[i] = 32'd0;
               chk($sformatf("u%0d_rst_done", i), obs_done[i], 32'd0);
               chk($sformatf("u%0d_rst_err", i), obs_err[i], 32'd0);
               chk($sformatf("u%0d_rst_rdata", i), obs_rdata[i], 32'd0);
            end else if (pend[i] && cyc == pend_done[i]) begin
               model_exec(i, e_m, ld_m, v_m);
               if (e_m) held[i] = 32'd0;
               else if (ld_m) held[i] = v_m;
               chk($sformatf("u%0d_done", i), obs_done[i], 32'd1);
               chk($sformatf("u%0d_err", i), obs_err[i], 32'(e_m));
               chk($sformatf("u%0d_stall_done", i), obs_stall[i], 32'd0);
               chk($sformatf("u%0d_rdata", i), obs_rdata[i], held[i]);
               pend[i] = 1'b0;
            end else begin
               chk($sformatf("u%0d_stall", i), obs_stall[i],
                   pend[i] ? 32'd1 : 32'(req_rd[i] | req_wr[i]));
               chk($sformatf("u%0d_nodone", i), obs_done[i], 32'd0);
               chk($sformatf("u%0d_noerr", i), obs_err[i], 32'd0);
               chk($sformatf("u%0d_hold", i), obs_rdata[i], held[i]);
               if (!pend[i] && (req_rd[i] || req_wr[i])) begin
                  pend[i]      = 1'b1;
                  p_rd[i]      = req_rd[i];
                  p_wr[i]      = req_wr[i];
                  p_addr[i]    = req_addr[i];
                  p_wdata[i]   = req_wdata[i];
                  p_f3[i]      = req_f3[i];
                  pend_done[i] = cyc + lat_of(i) + 1;
               end
            end
         end
      end
   end

   // Entered and left at posedge+1; enables stay asserted after done until the caller changes them.
   task automatic do_req(input int i, input bit rd, input bit wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [2:0] f, input bit scramble,
                         output logic [31:0] rdata, output bit e, output int stalls);
      bit got = 1'b0;
      req_rd[i] = rd; req_wr[i] = wr; req_addr[i] = a; req_wdata[i] = d; req_f3[i] = f;
      stalls = 0; rdata = 32'd0; e = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (obs_stall[i]) stalls++;
         if (obs_done[i]) begin
            got   = 1'b1;
            rdata = obs_rdata[i];
            e     = obs_err[i];
            break;
         end
         @(posedge clk); #1;
         if (scramble) begin
            req_addr[i]  = $urandom;
            req_wdata[i] = $urandom;
            req_f3[i]    = 3'($urandom);
         end
      end
      chk($sformatf("u%0d_done_seen", i), 32'(got), 32'd1);
      $display("txn u%0d rd=%0d wr=%0d addr=%h data=%h f3=%0d -> err=%0d rdata=%h stalls=%0d",
               i, rd, wr, a, d, f, e, rdata, stalls);
      @(posedge clk); #1;
   endtask

   task automatic run(input int i, input bit rd, input bit wr, input logic [31:0] a,
                      input logic [31:0] d, input logic [2:0] f, input string name,
                      input bit exp_err, input bit chk_rdata, input logic [31:0] exp_rdata,
                      input int exp_stalls);
      logic [31:0] r;
      bit          e;
      int          s;
      do_req(i, rd, wr, a, d, f, 1'b0, r, e, s);
      chk({name, "_err"}, 32'(e), 32'(exp_err));
      if (chk_rdata) chk({name, "_rdata"}, r, exp_rdata);
      if (exp_stalls >= 0) chk({name, "_stalls"}, 32'(s), 32'(exp_stalls));
   endtask

   task automatic idle(input int i, input int n);
      req_rd[i] = 1'b0;
      req_wr[i] = 1'b0;
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic random_traffic(input int i, input int n);
      logic [31:0] a, r;
      logic [2:0]  f;
      bit          rd, wr, e;
      int          s, sel, size;
      for (int t = 0; t < n; t++) begin
         sel = $urandom_range(0, 99);
         rd  = (sel < 47) || (sel >= 94);
         wr  = (sel >= 47);
         if ($urandom_range(0, 9) == 0) f = 3'($urandom);
         else if (rd && !wr) f = (sel % 5 < 3) ? 3'(sel % 5) : 3'(sel % 5 + 1);
         else f = 3'(sel % 3);
         a = ($urandom_range(0, 19) == 0) ? ($urandom | 32'h400) : 32'($urandom_range(0, 63));
         size = (f[1:0] == 2'd0) ? 1 : (f[1:0] == 2'd1) ? 2 : 4;
         if ($urandom_range(0, 3) != 0) a = a & ~32'(size - 1);
         do_req(i, rd, wr, a, $urandom, f, bit'($urandom_range(0, 1)), r, e, s);
         if ($urandom_range(0, 2) == 0) idle(i, $urandom_range(1, 3));
      end
      idle(i, 1);
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         req_rd[i] = 1'b0; req_wr[i] = 1'b0; req_addr[i] = 32'd0;
         req_wdata[i] = 32'd0; req_f3[i] = 3'd0;
      end
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk); #1;

      // Known contents for the window the traffic touches.
      for (int i = 0; i < 2; i++) begin
         for (int w = 0; w < 16; w++) run(i, 1'b0, 1'b1, 32'(w*4), 32'd0, 3'b010, "init", 1'b0, 1'b0, 32'd0, -1);
         idle(i, 1);
      end

      run(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 3'b010, "sw10", 1'b0, 1'b0, 32'd0, 3);
      run(0, 1'b1, 1'b0, 32'h10, 32'd0, 3'b010, "lw10", 1'b0, 1'b1, 32'hDEADBEEF, 3);
      run(0, 1'b0, 1'b1, 32'h21, 32'h000000F0, 3'b000, "sb21", 1'b0, 1'b0, 32'd0, 3);
      run(0, 1'b1, 1'b0, 32'h21, 32'd0, 3'b000, "lb21", 1'b0, 1'b1, 32'hFFFFFFF0, -1);
      run(0, 1'b1, 1'b0, 32'h21, 32'd0, 3'b100, "lbu21", 1'b0, 1'b1, 32'h000000F0, -1);
      run(0, 1'b1, 1'b0, 32'h20, 32'd0, 3'b010, "lw20", 1'b0, 1'b1, 32'h0000F000, -1);
      run(0, 1'b1, 1'b0, 32'h22, 32'd0, 3'b001, "lh22", 1'b0, 1'b1, 32'h00000000, -1);
      run(0, 1'b1, 1'b0, 32'h12, 32'd0, 3'b001, "lh12", 1'b0, 1'b1, 32'hFFFFDEAD, -1);
      run(0, 1'b1, 1'b0, 32'h12, 32'd0, 3'b010, "lw12", 1'b1, 1'b1, 32'd0, -1);
      run(0, 1'b0, 1'b1, 32'h13, 32'h0000AAAA, 3'b001, "sh13", 1'b1, 1'b1, 32'd0, -1);
      run(0, 1'b1, 1'b0, 32'h10, 32'd0, 3'b010, "lw10b", 1'b0, 1'b1, 32'hDEADBEEF, -1);
      run(0, 1'b1, 1'b0, 32'h400, 32'd0, 3'b010, "lw400", 1'b1, 1'b1, 32'd0, -1);
      run(0, 1'b1, 1'b0, 32'h10, 32'd0, 3'b011, "ld_bad", 1'b1, 1'b1, 32'd0, -1);
      run(0, 1'b1, 1'b1, 32'h24, 32'h11111111, 3'b010, "both", 1'b1, 1'b1, 32'd0, -1);
      run(0, 1'b1, 1'b0, 32'h24, 32'd0, 3'b010, "lw24", 1'b0, 1'b1, 32'd0, -1);
      run(0, 1'b0, 1'b1, 32'h30, 32'hCAFEF00D, 3'b010, "sw30", 1'b0, 1'b0, 32'd0, -1);
      run(0, 1'b1, 1'b0, 32'h10, 32'd0, 3'b010, "lw10c", 1'b0, 1'b1, 32'hDEADBEEF, -1);

      // Reset lands in BUSY of a store; the store must not commit.
      req_rd[0] = 1'b0; req_wr[0] = 1'b1; req_addr[0] = 32'h30;
      req_wdata[0] = 32'h12345678; req_f3[0] = 3'b010;
      @(negedge clk);
      chk("rst_accept_stall", 32'(obs_stall[0]), 32'd1);
      @(posedge clk); #1;
      req_wr[0] = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      chk("rst_async_rdata", obs_rdata[0], 32'd0);
      chk("rst_async_stall", 32'(obs_stall[0]), 32'd0);
      chk("rst_async_done", 32'(obs_done[0]), 32'd0);
      $display("txn u0 reset asserted during BUSY of SW 0x30");
      @(posedge clk); @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      run(0, 1'b1, 1'b0, 32'h30, 32'd0, 3'b010, "lw30", 1'b0, 1'b1, 32'hCAFEF00D, 3);
      idle(0, 1);

      // Latency-1 instance with enables held straight through DONE.
      run(1, 1'b0, 1'b1, 32'h8, 32'h5A5A5A5A, 3'b010, "b2b_sw1", 1'b0, 1'b0, 32'd0, 2);
      run(1, 1'b0, 1'b1, 32'h8, 32'h5A5A5A5A, 3'b010, "b2b_sw2", 1'b0, 1'b0, 32'd0, 2);
      run(1, 1'b1, 1'b0, 32'h8, 32'd0, 3'b010, "b2b_lw1", 1'b0, 1'b1, 32'h5A5A5A5A, 2);
      run(1, 1'b1, 1'b0, 32'h9, 32'd0, 3'b101, "b2b_lhu", 1'b1, 1'b1, 32'd0, 2);
      run(1, 1'b1, 1'b0, 32'hA, 32'd0, 3'b001, "b2b_lh", 1'b0, 1'b1, 32'h00005A5A, 2);
      idle(1, 2);

      random_traffic(0, 150);
      random_traffic(1, 150);

      idle(0, 2);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Data-memory responder that services load/store requests issued by the core's control path on data_mem_read_enable / data_mem_write_enable.
- Holds a word-organised local memory and performs byte, halfword and word accesses selected by funct3, with a fixed, parameterised access latency.
- Drives a stall to the core while an access is in flight, then pulses done with load data or an error flag.
- Sits between the core's ALU address output and the mem_to_reg_sel write-back multiplexer.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words in local memory; power of two.
- LATENCY, 2, cycles spent in BUSY before completion; legal range 1..15.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- data_mem_read_enable  input  1  load request (control decoder output).
- data_mem_write_enable  input  1  store request (control decoder output).
- addr  input  32  byte address (ALU result).
- write_data  input  32  store data (rs2_data); low bytes used for SB/SH.
- funct3  input  3  access size: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU for loads; 000 SB, 001 SH, 010 SW for stores.
- read_data  output  32  sign/zero-extended load result; valid in the done cycle and held until the next done.
- stall  output  1  core must hold the PC and the request.
- done  output  1  one-cycle completion pulse.
- err  output  1  qualifies done; access rejected.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; read_data=0, done=0, err=0, counter=0.
  - Memory contents are not reset.
- States:
  - IDLE: waits for a request.
  - BUSY: counts down the access latency.
  - DONE: completion cycle.
- stall is combinational: 1 when state==BUSY, or when state==IDLE and either enable=1. It is 0 in DONE.
- IDLE with either enable=1:
  - Latch addr, write_data, funct3 and kind (read or write).
  - Load counter with LATENCY-1 and go to BUSY.
- BUSY:
  - Decrement the counter each cycle.
  - When counter==0, perform the access and go to DONE.
  - Total request-to-done latency is LATENCY+1 cycles.
- DONE:
  - done=1 for exactly one cycle; err as computed.
  - Enables sampled in this cycle belong to the completing instruction and are ignored.
  - Return to IDLE. The next request is accepted no earlier than the following cycle.
- Access at the BUSY->DONE edge:
  - Word index = addr[log2(DEPTH_WORDS)+1:2].
  - Byte lane = addr[1:0].
  - Stores update only the selected lanes.
  - Loads extract the selected lanes:
    - LB/LH sign-extend from bit 7/15.
    - LBU/LHU zero-extend.
- Error conditions; err=1 in the done cycle, no memory write, read_data=0:
  - Both enables high at acceptance.
  - Misalignment: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0.
  - Out of range: addr[31:2] >= DEPTH_WORDS.
  - Illegal funct3: loads 011/110/111; stores any value other than 000/001/010.
- Request fields may change while stall=1; the latched copies are used.
- Reset during BUSY aborts the access. A store not yet committed (commit happens only at BUSY->DONE) leaves memory unchanged.
- read_data is unchanged by stores and by error completions other than being forced to 0 on error.

Test Plan:
- Store-then-load with LATENCY=2: SW addr=0x10 data=0xDEADBEEF, then LW addr=0x10 -> each access stalls 3 cycles, done pulses once, read_data=0xDEADBEEF.
- Byte lanes: SB addr=0x21 data=0x000000F0 over word 0x00000000:
  - LB 0x21 -> 0xFFFFFFF0.
  - LBU 0x21 -> 0x000000F0.
  - LW 0x20 -> 0x0000F000.
- Misalignment: LW addr=0x12 -> done with err=1, read_data=0. SH addr=0x13 -> err=1 and the word at 0x10 is unchanged.
- Out of range and conflict:
  - addr=0x400 with DEPTH_WORDS=256 -> err=1.
  - Both enables high -> err=1, no write.
- Reset mid-access: SW 0x30 data=0x12345678, assert rst_n=0 in BUSY -> outputs zeroed immediately; a subsequent LW 0x30 returns the prior contents.
- Back-to-back with LATENCY=1: enables held high through DONE -> exactly one done per instruction, stall drops in the DONE cycle, and the next request is accepted the cycle after.
